univ_shift_reg_param: RTL and testbench

//   Parametrised universal shift register: WIDTH-bit generalisation of the
//   4-bit hold/shift-right/shift-left/load register. Adds variable shift

---
 rtl/univ_shift_pkg.sv | 19 +
 rtl/shift_barrel.sv | 47 ++++
 rtl/univ_shift_reg_param.sv | 117 +++++++++++
 tb/tb_univ_shift_reg_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// serialiser state encoding.
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_SER  = 3'b111;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_RUN  = 1'b1
    } ser_state_e;

endpackage

// File: rtl/shift_barrel.sv
// Combinational shift/rotate unit: next register value for the shift and
// rotate modes; any other mode passes the data through unchanged.
module shift_barrel #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] d,
    input  logic [2:0]       mode,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] result
);
    import univ_shift_pkg::*;

    localparam logic [AMT_W:0]   WIDTH_EXT = (AMT_W + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONES      = '1;

    logic [AMT_W:0]   rev_d;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] asr_v;

    // d is always 1..WIDTH-1 here, so rev_d never reaches 0 or WIDTH
    assign rev_d = WIDTH_EXT - {1'b0, d};

    assign shr_v = (data >> d) | (msb_in ? ~(ONES >> d) : '0);
    assign shl_v = (data << d) | (lsb_in ? ~(ONES << d) : '0);
    assign ror_v = (data >> d) | (data << rev_d);
    assign rol_v = (data << d) | (data >> rev_d);
    assign asr_v = $signed(data) >>> d;

    always_comb begin
        result = data;
        case (mode)
            MODE_SHR: result = shr_v;
            MODE_SHL: result = shl_v;
            MODE_ROR: result = ror_v;
            MODE_ROL: result = rol_v;
            MODE_ASR: result = asr_v;
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_param.sv
// Parametrised universal shift register with variable-distance shifts,
// rotates, arithmetic shift and an LSB-first serialiser with busy/done.
//
// state    | meaning
// SER_IDLE | register follows mode_i; SER mode waits for start_i
// SER_RUN  | streaming loaded word LSB-first on ser_o, one bit per enabled cycle
module univ_shift_reg_param #(
    parameter int               WIDTH   = 8,
    parameter int               AMT_W   = $clog2(WIDTH),
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [WIDTH-1:0] I_par,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic             start_i,
    output logic [WIDTH-1:0] A_par,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);
    import univ_shift_pkg::*;

    localparam logic [AMT_W:0]   WIDTH_EXT = (AMT_W + 1)'(WIDTH);
    localparam logic [AMT_W-1:0] MAX_D     = AMT_W'(WIDTH - 1);

    ser_state_e       state_q, state_next;
    logic [WIDTH-1:0] a_q, a_next;
    logic [AMT_W-1:0] cnt_q, cnt_next;
    logic             done_q, done_next;
    logic [AMT_W-1:0] d_eff;
    logic [WIDTH-1:0] barrel_v;

    // Zero distance means one; distances past the top bit clamp to WIDTH-1
    always_comb begin
        d_eff = amt_i;
        if (amt_i == '0) begin
            d_eff = AMT_W'(1);
        end else if ({1'b0, amt_i} >= WIDTH_EXT) begin
            d_eff = MAX_D;
        end
    end

    shift_barrel #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_barrel (
        .data   (a_q),
        .d      (d_eff),
        .mode   (mode_i),
        .msb_in (msb_in),
        .lsb_in (lsb_in),
        .result (barrel_v)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SER_IDLE;
            a_q     <= RST_VAL;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            a_q     <= a_next;
            cnt_q   <= cnt_next;
            done_q  <= done_next;
        end
    end

    always_comb begin
        state_next = state_q;
        a_next     = a_q;
        cnt_next   = cnt_q;
        done_next  = 1'b0;

        if (clr_i) begin
            state_next = SER_IDLE;
            a_next     = RST_VAL;
            cnt_next   = '0;
        end else if (en_i) begin
            if (state_q == SER_RUN) begin
                a_next = {1'b0, a_q[WIDTH-1:1]};
                if (cnt_q == MAX_D) begin
                    state_next = SER_IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_q + AMT_W'(1);
                end
            end else begin
                case (mode_i)
                    MODE_HOLD: a_next = a_q;
                    MODE_LOAD: a_next = I_par;
                    MODE_SER: begin
                        if (start_i) begin
                            a_next     = I_par;
                            cnt_next   = '0;
                            state_next = SER_RUN;
                        end
                    end
                    default:   a_next = barrel_v;
                endcase
            end
        end
    end

    assign A_par  = a_q;
    assign busy_o = (state_q == SER_RUN);
    assign ser_o  = busy_o ? a_q[0] : 1'b0;
    assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Directed self-checking bench for univ_shift_reg_param at WIDTH=8.
module tb_univ_shift_reg_param;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clr_i;
    logic             en_i;
    logic [2:0]       mode_i;
    logic [AMT_W-1:0] amt_i;
    logic [WIDTH-1:0] I_par;
    logic             msb_in;
    logic             lsb_in;
    logic             start_i;
    logic [WIDTH-1:0] A_par;
    logic             ser_o;
    logic             busy_o;
    logic             done_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    univ_shift_reg_param #(
        .WIDTH   (WIDTH),
        .AMT_W   (AMT_W),
        .RST_VAL (8'h00)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .en_i    (en_i),
        .mode_i  (mode_i),
        .amt_i   (amt_i),
        .I_par   (I_par),
        .msb_in  (msb_in),
        .lsb_in  (lsb_in),
        .start_i (start_i),
        .A_par   (A_par),
        .ser_o   (ser_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clr_i = 1'b0; en_i = 1'b0; mode_i = 3'b000; amt_i = '0;
        I_par = '0; msb_in = 1'b0; lsb_in = 1'b0; start_i = 1'b0;
        #12;
        total++; if (A_par !== 8'h00) begin bad++; $display("FAIL reset_a: A_par=%h expected 00", A_par); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: busy_o=%b expected 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: done_o=%b expected 0", done_o); end
        total++; if (ser_o !== 1'b0) begin bad++; $display("FAIL reset_ser: ser_o=%b expected 0", ser_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_shift_modes();
        logic [2:0] t_mode [17] = '{3'b011, 3'b001, 3'b010, 3'b110, 3'b011, 3'b101, 3'b100, 3'b001,
                                    3'b010, 3'b000, 3'b111, 3'b100, 3'b110, 3'b010, 3'b001,
                                    3'b011, 3'b011};
        logic [2:0] t_amt  [17] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd4, 3'd0,
                                    3'd2, 3'd5, 3'd3, 3'd0, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};
        logic [7:0] t_data [17] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00,
                                    8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55};
        logic       t_msb  [17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       t_lsb  [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       t_en   [17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       t_clr  [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] t_exp  [17] = '{8'hA5, 8'hD2, 8'h90, 8'hE4, 8'h81, 8'h03, 8'h30, 8'h18,
                                    8'h63, 8'h63, 8'h63, 8'hB1, 8'hFF, 8'h80, 8'h01, 8'h01, 8'h00};
        for (int i = 0; i < 17; i++) begin
            mode_i = t_mode[i]; amt_i = t_amt[i]; I_par = t_data[i];
            msb_in = t_msb[i]; lsb_in = t_lsb[i]; en_i = t_en[i]; clr_i = t_clr[i];
            start_i = 1'b0;
            tick();
            total++;
            if (A_par !== t_exp[i]) begin
                bad++;
                $display("FAIL shift_step%0d: A_par=%h expected %h", i, A_par, t_exp[i]);
            end
            total++;
            if (busy_o !== 1'b0 || ser_o !== 1'b0) begin
                bad++;
                $display("FAIL shift_idle%0d: busy_o=%b ser_o=%b expected 0 0", i, busy_o, ser_o);
            end
        end
        clr_i = 1'b0; en_i = 1'b1; mode_i = 3'b000;
    endtask

    // Streams word_a and, on its done cycle, starts word_b back-to-back.
    task automatic test_back_to_back();
        logic [7:0] word_a = 8'hB4;
        logic [7:0] word_b = 8'h5A;
        en_i = 1'b1; mode_i = 3'b111; start_i = 1'b1; I_par = word_a;
        tick();
        // inputs that must be ignored while busy
        start_i = 1'b1; mode_i = 3'b011; I_par = 8'hFF; amt_i = 3'd5;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (busy_o !== 1'b1 || ser_o !== word_a[k] || done_o !== 1'b0) begin
                bad++;
                $display("FAIL ser_a_bit%0d: busy=%b ser=%b done=%b expected 1 %b 0", k, busy_o, ser_o, done_o, word_a[k]);
            end
            tick();
        end
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || ser_o !== 1'b0 || A_par !== 8'h00) begin
            bad++;
            $display("FAIL ser_a_done: done=%b busy=%b ser=%b A=%h expected 1 0 0 00", done_o, busy_o, ser_o, A_par);
        end
        mode_i = 3'b111; start_i = 1'b1; I_par = word_b;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (busy_o !== 1'b1 || ser_o !== word_b[k] || done_o !== 1'b0) begin
                bad++;
                $display("FAIL ser_b_bit%0d: busy=%b ser=%b done=%b expected 1 %b 0", k, busy_o, ser_o, done_o, word_b[k]);
            end
            tick();
        end
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL ser_b_done: done=%b busy=%b expected 1 0", done_o, busy_o);
        end
        tick();
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL ser_b_after: done=%b busy=%b expected 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_ser_hold();
        logic [7:0] word = 8'hB4;
        int         t_en  [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        int         t_bit [11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
        en_i = 1'b1; mode_i = 3'b111; start_i = 1'b1; I_par = word;
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 11; c++) begin
            en_i = (t_en[c] != 0);
            total++;
            if (busy_o !== 1'b1 || ser_o !== word[t_bit[c]] || done_o !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: busy=%b ser=%b done=%b expected 1 %b 0", c, busy_o, ser_o, done_o, word[t_bit[c]]);
            end
            tick();
        end
        en_i = 1'b1;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_end: busy=%b done=%b expected 0 1", busy_o, done_o);
        end
        mode_i = 3'b000;
        tick();
    endtask

    task automatic test_clr_during_ser();
        int done_seen = 0;
        en_i = 1'b1; mode_i = 3'b111; start_i = 1'b1; I_par = 8'hB4;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        total++;
        if (A_par !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b0 || ser_o !== 1'b0) begin
            bad++;
            $display("FAIL clr_ser: A=%h busy=%b done=%b ser=%b expected 00 0 0 0", A_par, busy_o, done_o, ser_o);
        end
        for (int c = 0; c < 10; c++) begin
            if (done_o === 1'b1 || busy_o === 1'b1) done_seen++;
            tick();
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL clr_no_done: active cycles=%0d expected 0", done_seen);
        end
        mode_i = 3'b000;
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        en_i = 1'b1; mode_i = 3'b111; start_i = 1'b1; I_par = 8'hC3;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (A_par !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b0 || ser_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: A=%h busy=%b done=%b ser=%b expected 00 0 0 0", A_par, busy_o, done_o, ser_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done_o === 1'b1 || busy_o === 1'b1) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL reset_no_done: active cycles=%0d expected 0", done_seen);
        end
        mode_i = 3'b000;
    endtask

    initial begin
        test_reset();
        test_shift_modes();
        test_back_to_back();
        test_ser_hold();
        test_clr_during_ser();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
